icache_line_adapter: RTL
========================

Name: icache_line_adapter

Overview:
- Sits between the instruction cache controller and physical memory.
- Converts a single-cycle-resolved 256-bit line-fill request from the icache (pmem_read / pmem_resp side) into a 4-beat x 64-bit read burst on the memory bus.
- Assembles the beats into one line and returns it with a one-cycle response.
- Read-only: the icache never writes back, so there is no write path.

Parameters:
LINE_WIDTH, 256, cache line width in bits
BURST_WIDTH, 64, memory beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH = 4
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
line_read  input  1  icache fill request (icache pmem_read); held high until line_resp
line_addr  input  ADDR_WIDTH  byte address of requested fetch
line_o  output  LINE_WIDTH  assembled line; valid only when line_resp=1
line_resp  output  1  one-cycle pulse: line_o valid, fill complete (drives icache pmem_resp)
burst_read  output  1  memory read request; held high for the whole burst
burst_addr  output  ADDR_WIDTH  burst start address, registered
burst_i  input  BURST_WIDTH  memory beat data
burst_resp  input  1  memory beat valid; may be non-contiguous

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, line_resp=0, burst_read=0, burst_addr=0, line_o=0, beat counter=0.
- IDLE:
  - If line_read=1, latch the address into burst_addr with the low 5 bits cleared (32-byte aligned).
  - Clear the beat counter and go to FILL.
  - burst_read rises the cycle after line_read is first seen.
- FILL:
  - burst_read=1.
  - On each cycle with burst_resp=1, write burst_i into line slot cnt (bits [64*cnt+63 : 64*cnt]), then cnt++.
  - On the beat where cnt==3, go to DONE. burst_read is still 1 in that cycle and drops to 0 the next cycle.
  - Cycles with burst_resp=0 hold all state.
- DONE:
  - line_resp=1 for exactly one cycle, with line_o holding all 4 beats; burst_read=0.
  - Next state is IDLE unconditionally.
- Latency: from line_read rising to line_resp is 1 (IDLE) + N (beats, at least 4) + 1 (DONE) cycles. With back-to-back memory beats: line_read at cycle 0 -> line_resp at cycle 5.
- line_addr changes while in FILL/DONE are ignored; the latched address is authoritative.
- line_read dropping mid-FILL: the burst still completes and line_resp still pulses; the memory transaction is never abandoned.
- burst_resp while in IDLE or DONE: ignored; no slot written, counter unchanged.
- The icache deasserts line_read the cycle after line_resp. IDLE re-samples line_read, so a request held at 1 after DONE starts a new fill. This is correct behaviour, not an error.
- line_o retains the last assembled line between fills. Slots are overwritten beat by beat during the next fill.
- rst asserted mid-FILL or in DONE: return to IDLE next edge, all outputs to reset values, partial line discarded, no line_resp.

Optional Feature:
- Macro: ICACHE_LINE_ADAPTER_CRIT_WORD_EN.
- When defined (critical-word-first):
  - burst_addr keeps line_addr[4:3] and clears only bits [2:0].
  - Memory returns beats in wrap order starting at word w = line_addr[4:3].
  - Beat k is written to slot (w+k) mod 4, using 2-bit wrap-around addition.
  - line_o layout is identical to the non-feature build.
- When undefined: burst_addr[4:0]=0 and beat k goes to slot k.
- Latency and handshake are the same in both builds.

Test Plan:
- Basic fill:
  - Stimulus: line_read=1, line_addr=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - Response: burst_addr=0x0000_1220; line_resp at cycle 5 for one cycle; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Stalled beats:
  - Stimulus: same request, burst_resp on cycles 2, 5, 6, 9.
  - Response: burst_read=1 through cycle 9 and 0 at cycle 10; line_resp only at cycle 10; line_o correct.
- Spurious and late inputs:
  - Stimulus: burst_resp=1 while IDLE; line_addr changed to 0xFFFF_FFE0 mid-FILL.
  - Response: no slot written; burst_addr unchanged; line_o unaffected.
- Reset mid-burst:
  - Stimulus: rst=1 after 2 beats.
  - Response: next cycle state IDLE, burst_read=0, line_o=0, no line_resp.
  - Follow-up: a new request then completes normally with 4 fresh beats.
- Back-to-back requests:
  - Stimulus: line_read held high across DONE.
  - Response: second fill starts in the cycle after DONE; two distinct line_resp pulses; no beat lost.
- With ICACHE_LINE_ADAPTER_CRIT_WORD_EN:
  - Stimulus: line_addr=0x0000_1250, beats A, B, C, D.
  - Response: burst_addr=0x0000_1250; line_o = {B, A, D, C} (slot2=A, slot3=B, slot0=C, slot1=D).

Source files
------------

// File: rtl/icache_line_adapter.sv
// Read-only line-fill adapter: one 256-bit icache fill becomes a 4-beat x 64-bit memory burst.
// Define ICACHE_LINE_ADAPTER_CRIT_WORD_EN for critical-word-first (wrap-order) bursts.
module icache_line_adapter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_read,
    input  logic [ADDR_WIDTH-1:0]  line_addr,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   line_resp,
    output logic                   burst_read,
    output logic [ADDR_WIDTH-1:0]  burst_addr,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   burst_resp
);

    localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_LSB = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef ICACHE_LINE_ADAPTER_CRIT_WORD_EN
    localparam int WORD_LSB = $clog2(BURST_WIDTH / 8);
    // Keep the word index so memory starts the wrap at the critical word.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'((1 << WORD_LSB) - 1));
`else
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'((1 << LINE_LSB) - 1));
`endif

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] slot;
    logic             beat_take;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next = state;
        burst_read = 1'b0;
        line_resp  = 1'b0;
        beat_take  = 1'b0;
        case (state)
            IDLE: begin
                if (line_read) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                burst_read = 1'b1;
                if (burst_resp) begin
                    beat_take = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                line_resp  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ICACHE_LINE_ADAPTER_CRIT_WORD_EN
    // Wrap-around slot: the CNT_W-bit sum drops the carry on purpose.
    assign slot = burst_addr[LINE_LSB-1:WORD_LSB] + cnt;
`else
    assign slot = cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: line_o is cleared on reset so a discarded partial line is never visible.
            cnt        <= '0;
            burst_addr <= '0;
            line_o     <= '0;
        end else begin
            if (state == IDLE && line_read) begin
                burst_addr <= line_addr & ALIGN_MASK;
                cnt        <= '0;
            end
            if (beat_take) begin
                cnt <= cnt + CNT_W'(1);
                for (int b = 0; b < BEATS; b++) begin
                    if (slot == CNT_W'(b)) begin
                        line_o[b*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                    end
                end
            end
        end
    end

endmodule
